// File: rtl/alu_seq_if.sv
// Handshake bundle for the sequential execute unit: request side (op, operands, kill)
// and result side (result plus flags), each with its own valid/ready pair.
interface alu_seq_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            kill;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            lt;
    logic            ltu;
    logic            zero;
    logic            illegal;

    modport master (
        output in_valid, op, a, b, kill, out_ready,
        input  in_ready, out_valid, result, lt, ltu, zero, illegal
    );

    modport slave (
        input  in_valid, op, a, b, kill, out_ready,
        output in_ready, out_valid, result, lt, ltu, zero, illegal
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked execute unit: single-cycle base integer ops, plus iterative radix-2
// multiply/divide when ALU_SEQ_MULDIV_EN is defined (otherwise those codes are illegal).
module alu_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input logic      clk,
    input logic      reset,
    alu_seq_if.slave bus
);
    localparam int              SH_W   = $clog2(XLEN);
    localparam logic [XLEN-1:0] ZERO_C = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES_C = {XLEN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            lt_q, lt_d;
    logic            ltu_q, ltu_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;

    logic            accept_s;
    logic            lt_s;
    logic            ltu_s;
    logic [SH_W-1:0] shamt_s;
    logic [XLEN-1:0] base_res_s;
    logic            base_ill_s;
    logic            go_busy_s;
    logic [XLEN-1:0] imm_res_s;
    logic            imm_ill_s;
    logic            busy_last_s;
    logic [XLEN-1:0] md_res_s;

    // A kill in IDLE blocks acceptance of a simultaneous request.
    assign accept_s = (state_q == S_IDLE) && bus.in_valid && !bus.kill;
    assign lt_s     = $signed(bus.a) < $signed(bus.b);
    assign ltu_s    = bus.a < bus.b;
    assign shamt_s  = bus.b[SH_W-1:0];

    // Base integer result and illegal-code decode for the offered op.
    always_comb begin
        base_res_s = ZERO_C;
        base_ill_s = 1'b0;
        case (bus.op)
            5'b0_0000: base_res_s = bus.a + bus.b;
            5'b0_0001: base_res_s = bus.a - bus.b;
            5'b0_0010: base_res_s = bus.a ^ bus.b;
            5'b0_0011: base_res_s = bus.a | bus.b;
            5'b0_0100: base_res_s = bus.a & bus.b;
            5'b0_0101: base_res_s = bus.a << shamt_s;
            5'b0_0110: base_res_s = bus.a >> shamt_s;
            5'b0_0111: base_res_s = $unsigned($signed(bus.a) >>> shamt_s);
            5'b0_1000: base_res_s = {{(XLEN-1){1'b0}}, lt_s};
            5'b0_1001: base_res_s = {{(XLEN-1){1'b0}}, ltu_s};
            default:   base_ill_s = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_MULDIV_EN
    localparam logic [CNT_W-1:0] CNT_ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO_C = {CNT_W{1'b0}};
    localparam logic [XLEN-1:0]  MIN_NEG_C  = {1'b1, {(XLEN-1){1'b0}}};

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        md_op_q, md_op_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;

    logic              md_s, a_sgn_s, b_sgn_s, div_zero_s, ovf_s;
    logic [XLEN-1:0]   a_mag_s, b_mag_s, spec_res_s;
    logic [XLEN:0]     mul_sum_s, div_r_s, div_diff_s;
    logic              div_ge_s;
    logic [2*XLEN-1:0] acc_step_s, prod_s;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (ZERO_C - v) : v;
    endfunction

    // Operand signedness per op, magnitudes and the divide special cases.
    always_comb begin
        md_s = (bus.op[4:3] == 2'b10);
        if (bus.op[2]) begin
            a_sgn_s = bus.a[XLEN-1] & ~bus.op[0];
            b_sgn_s = bus.b[XLEN-1] & ~bus.op[0];
        end else begin
            a_sgn_s = bus.a[XLEN-1] & ~(bus.op[1] & bus.op[0]);
            b_sgn_s = bus.b[XLEN-1] & ~bus.op[1];
        end
        a_mag_s    = cond_neg(bus.a, a_sgn_s);
        b_mag_s    = cond_neg(bus.b, b_sgn_s);
        div_zero_s = bus.op[2] && (bus.b == ZERO_C);
        ovf_s      = bus.op[2] && !bus.op[0] && (bus.a == MIN_NEG_C) && (bus.b == ONES_C);
        if (div_zero_s) begin
            spec_res_s = bus.op[1] ? bus.a : ONES_C;
        end else if (ovf_s) begin
            spec_res_s = bus.op[1] ? ZERO_C : bus.a;
        end else begin
            spec_res_s = ZERO_C;
        end
    end

    assign go_busy_s   = md_s && !div_zero_s && !ovf_s;
    assign imm_res_s   = md_s ? spec_res_s : base_res_s;
    assign imm_ill_s   = md_s ? 1'b0 : base_ill_s;
    assign busy_last_s = (cnt_q == CNT_ONE_C);

    // One shift-add or restoring-subtract step, plus the sign fix-up of the final step.
    always_comb begin
        mul_sum_s  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
        div_r_s    = acc_q[2*XLEN-1:XLEN-1];
        div_diff_s = div_r_s - {1'b0, mcand_q};
        div_ge_s   = ~div_diff_s[XLEN];
        if (md_op_q[2]) begin
            acc_step_s = {(div_ge_s ? div_diff_s[XLEN-1:0] : div_r_s[XLEN-1:0]),
                          acc_q[XLEN-2:0], div_ge_s};
        end else begin
            acc_step_s = {mul_sum_s, acc_q[XLEN-1:1]};
        end
        prod_s = qneg_q ? ({(2*XLEN){1'b0}} - acc_step_s) : acc_step_s;
        if (md_op_q[2]) begin
            md_res_s = md_op_q[1] ? cond_neg(acc_step_s[2*XLEN-1:XLEN], rneg_q)
                                  : cond_neg(acc_step_s[XLEN-1:0], qneg_q);
        end else begin
            md_res_s = (md_op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        end
    end

    // Iterative datapath next state: load on accept, step while BUSY.
    always_comb begin
        acc_d   = acc_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        md_op_d = md_op_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        if (accept_s && go_busy_s) begin
            acc_d   = {ZERO_C, (bus.op[2] ? a_mag_s : b_mag_s)};
            mcand_d = bus.op[2] ? b_mag_s : a_mag_s;
            cnt_d   = CNT_W'(XLEN);
            md_op_d = bus.op[2:0];
            qneg_d  = a_sgn_s ^ b_sgn_s;
            rneg_d  = a_sgn_s;
        end else if (state_q == S_BUSY) begin
            if (bus.kill) begin
                cnt_d = CNT_ZERO_C;
            end else begin
                acc_d = acc_step_s;
                cnt_d = cnt_q - CNT_ONE_C;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Iterative datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q   <= {(2*XLEN){1'b0}};
            mcand_q <= ZERO_C;
            cnt_q   <= CNT_ZERO_C;
            md_op_q <= 3'b000;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            md_op_q <= md_op_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end
`else
    assign go_busy_s   = 1'b0;
    assign imm_res_s   = base_res_s;
    assign imm_ill_s   = base_ill_s;
    assign busy_last_s = 1'b0;
    assign md_res_s    = ZERO_C;
`endif

    // Control FSM next state and registered result/flag updates.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        lt_d      = lt_q;
        ltu_d     = ltu_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    lt_d  = lt_s;
                    ltu_d = ltu_s;
                    if (go_busy_s) begin
                        state_d = S_BUSY;
                    end else begin
                        state_d   = S_DONE;
                        result_d  = imm_res_s;
                        illegal_d = imm_ill_s;
                        zero_d    = (imm_res_s == ZERO_C);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (bus.kill) begin
                    state_d = S_IDLE;
                end else if (busy_last_s) begin
                    state_d   = S_DONE;
                    result_d  = md_res_s;
                    illegal_d = 1'b0;
                    zero_d    = (md_res_s == ZERO_C);
                end else begin
                    state_d = S_BUSY;
                end
            end
            S_DONE: begin
                if (bus.kill || bus.out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state, result and flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            result_q  <= ZERO_C;
            lt_q      <= 1'b0;
            ltu_q     <= 1'b0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            lt_q      <= lt_d;
            ltu_q     <= ltu_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.lt        = lt_q;
    assign bus.ltu       = ltu_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (XLEN=32); multiply/divide expectations
// follow whether ALU_SEQ_MULDIV_EN is defined for the build.
module tb_alu_seq;
    localparam int XLEN = 32;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [7:0]  lat;
    } vec_t;

    localparam vec_t BASE_V [11] = '{
        '{5'd0, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 8'd1},
        '{5'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 8'd1},
        '{5'd1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 8'd1},
        '{5'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 8'd1},
        '{5'd3, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 8'd1},
        '{5'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 8'd1},
        '{5'd5, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 8'd1},
        '{5'd6, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 8'd1},
        '{5'd7, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 8'd1},
        '{5'd8, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 8'd1},
        '{5'd9, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 8'd1}
    };

    localparam vec_t MD_V [14] = '{
        '{5'b10001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 8'd33},
        '{5'b10000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 8'd33},
        '{5'b10000, 32'h0000_0006, 32'hFFFF_FFF9, 32'hFFFF_FFD6, 8'd33},
        '{5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 8'd33},
        '{5'b10010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd33},
        '{5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 8'd1},
        '{5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 8'd1},
        '{5'b10101, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 8'd1},
        '{5'b10111, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 8'd1},
        '{5'b10100, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 8'd1},
        '{5'b10110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 8'd33},
        '{5'b10100, 32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 8'd33},
        '{5'b10110, 32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 8'd33},
        '{5'b10101, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 8'd33}
    };

    logic clk = 1'b0;
    logic reset;
    int   n_run  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_seq_if #(.XLEN(XLEN)) bus ();

    alu_seq #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Counts cycles after the accepting edge until out_valid, stopping at limit.
    task automatic wait_valid(input int limit, output int cyc);
        cyc = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            cyc++;
            if (bus.out_valid) break;
        end
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int          cyc;
        logic        seen;
        logic [31:0] exp_r;
        logic        exp_ill;
        int          exp_lat;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = 5'd0;
        bus.a         = 32'd0;
        bus.b         = 32'd0;
        bus.kill      = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_in_ready", bus.in_ready, 1);
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_result", bus.result, 0);
        check_eq("rst_flags", {bus.lt, bus.ltu, bus.zero, bus.illegal}, 0);

        // SUB 5-7 with flags and the post-handshake in_ready
        issue(5'd1, 32'd5, 32'd7);
        @(negedge clk);
        check_eq("sub_valid", bus.out_valid, 1);
        check_eq("sub_result", bus.result, 32'hFFFF_FFFE);
        check_eq("sub_lt_ltu_zero", {bus.lt, bus.ltu, bus.zero}, 3'b110);
        check_eq("sub_in_ready_done", bus.in_ready, 0);
        consume();
        @(negedge clk);
        check_eq("sub_in_ready_after", bus.in_ready, 1);
        check_eq("sub_valid_after", bus.out_valid, 0);

        for (int i = 0; i < 11; i++) begin
            issue(BASE_V[i].op, BASE_V[i].a, BASE_V[i].b);
            wait_valid(3, cyc);
            check_eq($sformatf("base%0d_lat", i), cyc, BASE_V[i].lat);
            check_eq($sformatf("base%0d_res", i), bus.result, BASE_V[i].r);
            check_eq($sformatf("base%0d_zero", i), bus.zero, BASE_V[i].r == 32'd0);
            check_eq($sformatf("base%0d_ill", i), bus.illegal, 0);
            consume();
        end

        // illegal code 0_1111
        issue(5'b0_1111, 32'd3, 32'd9);
        @(negedge clk);
        check_eq("ill_valid", bus.out_valid, 1);
        check_eq("ill_result", bus.result, 0);
        check_eq("ill_flag", bus.illegal, 1);
        check_eq("ill_lt_ltu", {bus.lt, bus.ltu}, 2'b11);
        consume();

        for (int i = 0; i < 14; i++) begin
`ifdef ALU_SEQ_MULDIV_EN
            exp_r   = MD_V[i].r;
            exp_ill = 1'b0;
            exp_lat = int'(MD_V[i].lat);
`else
            exp_r   = 32'd0;
            exp_ill = 1'b1;
            exp_lat = 1;
`endif
            issue(MD_V[i].op, MD_V[i].a, MD_V[i].b);
            wait_valid(40, cyc);
            check_eq($sformatf("md%0d_lat", i), cyc, exp_lat);
            check_eq($sformatf("md%0d_res", i), bus.result, exp_r);
            check_eq($sformatf("md%0d_ill", i), bus.illegal, exp_ill);
            consume();
        end

        // backpressure: DONE holds while out_ready stays low
        issue(5'd0, 32'd3, 32'd4);
        wait_valid(3, cyc);
        for (int i = 0; i < 10; i++) begin
            check_eq("bp_result", bus.result, 32'd7);
            check_eq("bp_hold", {bus.out_valid, bus.in_ready}, 2'b10);
            @(negedge clk);
        end
        consume();
        @(negedge clk);
        check_eq("bp_release_in_ready", bus.in_ready, 1);

        // kill mid-operation (BUSY cycle 5 of a DIV, or DONE when compiled out)
`ifdef ALU_SEQ_MULDIV_EN
        issue(5'b10100, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
`else
        issue(5'b00000, 32'd100, 32'd7);
`endif
        @(negedge clk);
        bus.kill = 1'b1;
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        @(negedge clk);
        check_eq("kill_idle", {bus.in_ready, bus.out_valid}, 2'b10);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check_eq("kill_no_valid", seen, 0);
        issue(5'd0, 32'd1, 32'd1);
        wait_valid(3, cyc);
        check_eq("kill_then_add", bus.result, 32'd2);
        consume();

        // kill in IDLE blocks a simultaneous request
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.kill     = 1'b1;
        bus.op       = 5'd0;
        bus.a        = 32'd8;
        bus.b        = 32'd8;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.kill     = 1'b0;
        @(negedge clk);
        check_eq("kill_idle_reject", {bus.in_ready, bus.out_valid}, 2'b10);

        // reset in the middle of an operation
        issue(5'b10101, 32'd3, 32'd100);
`ifdef ALU_SEQ_MULDIV_EN
        repeat (3) @(negedge clk);
`else
        @(negedge clk);
`endif
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_ready_valid", {bus.in_ready, bus.out_valid}, 2'b10);
        check_eq("mid_rst_result", bus.result, 0);
        check_eq("mid_rst_flags", {bus.lt, bus.ltu, bus.zero, bus.illegal}, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked execute unit that succeeds the combinational ALU. Base integer ops (ADD through SLTU) complete in one registered cycle. With the multiply/divide option compiled in, it also runs the RV32M/RV64M multiply and divide ops on an iterative radix-2 datapath. It sits in the execute stage between operand forwarding and writeback and stalls the pipeline through a valid/ready handshake on both sides.

## Interface
- XLEN, 32: operand and result width; legal values are 32 and 64.
- CNT_W, $clog2(XLEN)+1: width of the iteration counter.
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept an operation; high only in IDLE.
- op  in  5  operation code:
  - 0_0000 to 0_1001 keep the base encoding: ADD, SUB, XOR, OR, AND, SLL, SRL, SRA, SLT, SLTU.
  - 1_0000 to 1_0111 are MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - All other codes are illegal.
- a, b  in  XLEN each  operands.
- kill  in  1  abort the operation in flight (pipeline flush).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- result  out  XLEN  registered result.
- lt, ltu, zero  out  1 each  registered flags:
  - lt: signed a<b.
  - ltu: unsigned a<b.
  - zero: result==0.
- illegal  out  1  the op code was illegal or is compiled out.

## Operation
- States:
  - IDLE: in_ready=1.
  - BUSY: iterating.
  - DONE: out_valid=1.
- IDLE, in_valid=1:
  - Latch op, a and b.
  - Compute lt and ltu from the accepted a and b.
  - Base op or illegal op: go to DONE; result and illegal are registered in the same edge.
  - MUL or DIV group: go to BUSY with cnt=XLEN.
  - Special cases go straight to DONE:
    - divide by zero: quotient=all ones, remainder=a.
    - signed overflow (a=most-negative, b=-1): quotient=a, remainder=0.
- BUSY, multiply:
  - Shift-add over |a| and |b|, one bit per cycle, into a 2*XLEN accumulator.
  - Apply the sign fix-up in the final cycle.
  - Sign handling per op: MULHSU treats a as signed and b as unsigned; MULHU treats both as unsigned.
  - MUL returns the low XLEN bits; the MULH variants return the high XLEN bits.
- BUSY, divide:
  - Restoring division on magnitudes, one quotient bit per cycle.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
- BUSY: cnt decrements each cycle; at cnt==1 the unit goes to DONE and writes result.
- DONE: hold result and flags stable until out_valid and out_ready are both high, then go to IDLE.
- kill:
  - In BUSY or DONE: go to IDLE next cycle; no out_valid is produced for that operation.
  - In IDLE: no effect; an in_valid in the same cycle is not accepted.
- reset:
  - state=IDLE, in_ready=1, out_valid=0, result=0, lt=ltu=zero=0, illegal=0, cnt=0.
  - Reset has priority over kill and any handshake, including mid-iteration.
- Shift amounts use b[$clog2(XLEN)-1:0].
- All arithmetic wraps modulo 2^XLEN.

## Timing
- Base, illegal or special-case op accepted at edge t: out_valid=1 from t+1.
- MUL or DIV group accepted at t: BUSY during t+1 to t+XLEN; out_valid=1 from t+XLEN+1.
- Output handshake completes at edge u: out_valid=0 and in_ready=1 from u+1.
- Throughput: at most one op per 2 cycles for base ops.
- in_ready never depends combinationally on out_ready.
- out_ready held low: DONE persists indefinitely with outputs unchanged.

## Configuration
- ALU_SEQ_MULDIV_EN defined:
  - Op codes 1_0000 to 1_0111 execute as described above.
- ALU_SEQ_MULDIV_EN undefined:
  - The multiply/divide datapath, accumulator and counter are removed.
  - Op codes 1_xxxx take the illegal path: one-cycle latency, result=0, illegal=1, flags computed normally.
  - The BUSY state is unreachable.

## Test plan
- Base op, XLEN=32: SUB with a=5, b=7.
  - Required at t+1: result=0xFFFFFFFE, lt=1, ltu=1, zero=0.
  - After the handshake: in_ready=1 the following cycle.
- MULH: a=0x80000000, b=0x80000000.
  - Required: out_valid exactly 33 cycles after accept, result=0x40000000.
  - MUL with the same operands: result=0.
- Divide special cases:
  - DIV 0x80000000 / 0xFFFFFFFF: result=0x80000000, latency 1.
  - DIVU 7 / 0: result=0xFFFFFFFF.
  - REM -7 / 2: result=0xFFFFFFFF.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - Required: result stable, in_ready=0.
  - Release out_ready: in_ready=1 on the next cycle.
- kill asserted in BUSY cycle 5 of a DIV.
  - Required: IDLE next cycle, out_valid never asserts.
  - A following ADD 1+1 returns result=2.
- Illegal op 0_1111: result=0, illegal=1 at t+1.
- Macro undefined: op 1_0000 gives result=0, illegal=1 at t+1.
- Reset asserted mid-BUSY: all outputs return to their reset values on the next edge.
